// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment scan controller: the blank
// pattern, the active-low hex-to-segment table and an index-width helper.
package sseg_pkg;

    // All segments and the decimal point dark (active low).
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low {g,f,e,d,c,b,a} patterns, entry n shows hex digit n.
    // The first element of the concatenation is entry 15.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    // Width of a digit index; a single-digit display still gets one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational hex digit to active-low seven-segment decoder.
module hex7seg_dec
    import sseg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Straight table lookup; every 4-bit code has an entry.
    assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode display.
// Inputs are snapshotted once per frame; blink, blanking, leading-zero
// suppression and PWM dimming gate each slot; an/sseg are registered.
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int N_DIGITS   = 4,
    parameter int DIV_LOG2   = 16,
    parameter int PWM_BITS   = 4,
    parameter int BLINK_LOG2 = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*N_DIGITS-1:0]   hex_in,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic [N_DIGITS-1:0]     blank_in,
    input  logic [N_DIGITS-1:0]     blink_en,
    input  logic                    lz_blank,
    input  logic [PWM_BITS-1:0]     bright,
    output logic [N_DIGITS-1:0]     an,
    output logic [7:0]              sseg,
    output logic                    frame_tick
);

    localparam int             IW       = idx_w(N_DIGITS);
    localparam logic [IW-1:0]  IDX_LAST = IW'(N_DIGITS - 1);

    // Scan counters
    logic [DIV_LOG2-1:0]    div_cnt;
    logic [IW-1:0]          digit_idx;
    logic [BLINK_LOG2-1:0]  frame_cnt;
    logic                   blink_ph;
    logic                   load_pend;

    // Frame snapshot of every input
    logic [N_DIGITS-1:0][3:0] hex_snap;
    logic [N_DIGITS-1:0]      dp_snap;
    logic [N_DIGITS-1:0]      blank_snap;
    logic [N_DIGITS-1:0]      blink_snap;
    logic                     lz_snap;
    logic [PWM_BITS-1:0]      bright_snap;

    // Slot gating
    logic                  slot_end;
    logic                  frame_end;
    logic [PWM_BITS-1:0]   phase;
    logic                  pwm_on;
    logic [N_DIGITS-1:0]   lz_zero;
    logic [N_DIGITS-1:0]   suppress;
    logic                  hi_zero;
    logic [3:0]            cur_hex;
    logic [6:0]            cur_seg;
    logic                  lit;

    assign slot_end  = &div_cnt;
    assign frame_end = slot_end && (digit_idx == IDX_LAST);

    // Slot divider and digit pointer; a single-digit build keeps the pointer at 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt   <= '0;
            digit_idx <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
            if (slot_end)
                digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
        end
    end

    // Frame counter drives the blink phase, which flips once per counter wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
            blink_ph  <= 1'b0;
        end else if (frame_end) begin
            frame_cnt <= frame_cnt + 1'b1;
            if (&frame_cnt)
                blink_ph <= ~blink_ph;
        end
    end

    // Capture all inputs at frame end (or right after reset) so a frame is never mixed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_pend   <= 1'b1;
            hex_snap    <= '0;
            dp_snap     <= '1;
            blank_snap  <= '1;
            blink_snap  <= '0;
            lz_snap     <= 1'b0;
            bright_snap <= '0;
        end else begin
            load_pend <= 1'b0;
            if (frame_end || load_pend) begin
                hex_snap    <= hex_in;
                dp_snap     <= dp_in;
                blank_snap  <= blank_in;
                blink_snap  <= blink_en;
                lz_snap     <= lz_blank;
                bright_snap <= bright;
            end
        end
    end

    // Leading-zero mask: a digit is suppressible when it and all digits above are zero.
    always_comb begin
        lz_zero = '0;
        hi_zero = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            hi_zero    = hi_zero && (hex_snap[i] == 4'h0);
            lz_zero[i] = hi_zero;
        end
        suppress    = lz_snap ? lz_zero : '0;
        suppress[0] = 1'b0;
    end

    // PWM: the top bits of the slot divider sweep the duty; all-ones means full on.
    assign phase  = div_cnt[DIV_LOG2-1 -: PWM_BITS];
    assign pwm_on = (&bright_snap) || (phase < bright_snap);

    assign cur_hex = hex_snap[digit_idx];

    hex7seg_dec u_dec (
        .hex (cur_hex),
        .seg (cur_seg)
    );

    // The snapshot is not yet valid on the first edge after reset, so stay dark then.
    assign lit = !load_pend
              && !blank_snap[digit_idx]
              && !(blink_ph && blink_snap[digit_idx])
              && !suppress[digit_idx]
              && pwm_on;

    // Registered pin drivers; at most one anode low, frame_tick aligned with the new snapshot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an         <= '1;
            sseg       <= SEG_OFF;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_end;
            if (lit) begin
                an   <= ~(N_DIGITS'(1) << digit_idx);
                sseg <= {dp_snap[digit_idx], cur_seg};
            end else begin
                an   <= '1;
                sseg <= SEG_OFF;
            end
        end
    end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Scoreboard bench for sseg_scan_ctrl: expectations for a frame are queued
// when its snapshot is taken, then popped against the pins slot by slot.
module tb_sseg_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] hex_in;
    logic [3:0]  dp_in, blank_in, blink_en;
    logic        lz_blank;
    logic [1:0]  bright;
    logic [3:0]  an;
    logic [7:0]  sseg;
    logic        frame_tick;

    int n_vec = 0;
    int n_err = 0;
    int tick_cnt;

    typedef struct {
        int         cyc;
        int         dig;
        int         pos;
        logic [3:0] an;
        logic [7:0] sseg;
    } exp_t;

    exp_t sb[$];

    sseg_scan_ctrl #(
        .N_DIGITS   (4),
        .DIV_LOG2   (4),
        .PWM_BITS   (2),
        .BLINK_LOG2 (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .hex_in     (hex_in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .blink_en   (blink_en),
        .lz_blank   (lz_blank),
        .bright     (bright),
        .an         (an),
        .sseg       (sseg),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // Frames completed since reset; bit 1 is the blink phase of the current frame.
    always @(negedge clk or posedge reset) begin
        if (reset)           tick_cnt <= 0;
        else if (frame_tick) tick_cnt <= tick_cnt + 1;
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg7(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    // Expected {an, sseg} for digit d at slot position pos, from the driven inputs.
    function automatic logic [11:0] expect_out(input int d, input int pos, input logic ph);
        logic [3:0]  h;
        logic [15:0] upper;
        logic        sup, pwm, lit;
        logic [3:0]  one;
        h     = hex_in[4*d +: 4];
        upper = hex_in >> (4*d);
        sup   = (d > 0) && lz_blank && (upper == 16'h0);
        pwm   = (bright == 2'b11) || ((pos / 4) < int'(bright));
        lit   = !blank_in[d] && !(ph && blink_en[d]) && !sup && pwm;
        one   = 4'b0001 << d;
        if (lit) return {~one, dp_in[d], seg7(h)};
        return {4'hF, 8'hFF};
    endfunction

    task automatic wait_tick(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("tick_timeout", 16'd0, 16'd1);
    endtask

    // Waits for the snapshot of the current inputs, queues the frame's
    // expectations, then checks cycles 1..63 of that frame. Optionally
    // changes hex_in mid-frame at cycle chg_cyc.
    task automatic run_frame(input int full, input int chg_cyc, input logic [15:0] chg_hex);
        logic        ok;
        logic        ph;
        logic [11:0] e;
        exp_t        it;
        wait_tick(ok);
        if (!ok) return;
        #1;
        ph = tick_cnt[1];
        for (int d = 0; d < 4; d++)
            for (int p = 0; p < 16; p++)
                if ((full != 0 || p == 0 || p == 7 || p == 14) && (16*d + p + 1) <= 63) begin
                    e = expect_out(d, p, ph);
                    sb.push_back('{cyc: 16*d + p + 1, dig: d, pos: p, an: e[11:8], sseg: e[7:0]});
                end
        for (int j = 1; j <= 63; j++) begin
            @(negedge clk);
            if (j == 1) chk("tick_width", {15'd0, frame_tick}, 16'd0);
            while (sb.size() > 0 && sb[0].cyc == j) begin
                it = sb.pop_front();
                chk($sformatf("an d%0d p%0d", it.dig, it.pos), {12'd0, an}, {12'd0, it.an});
                chk($sformatf("sseg d%0d p%0d", it.dig, it.pos), {8'd0, sseg}, {8'd0, it.sseg});
            end
            if (j == chg_cyc) hex_in = chg_hex;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          n;
        logic [11:0] e;
        reset    = 1'b1;
        hex_in   = 16'h1234;
        dp_in    = 4'b1011;
        blank_in = 4'b0000;
        blink_en = 4'b0000;
        lz_blank = 1'b0;
        bright   = 2'b11;
        #13;
        chk("rst_an",   {12'd0, an},   16'h000F);
        chk("rst_sseg", {8'd0, sseg},  16'h00FF);
        chk("rst_tick", {15'd0, frame_tick}, 16'd0);
        @(negedge clk);
        reset = 1'b0;

        // Basic scan, twice to see it repeat
        run_frame(0, 0, 16'h0);
        run_frame(0, 0, 16'h0);

        // Mid-frame change is held off until the next snapshot
        run_frame(0, 20, 16'hABCD);
        run_frame(0, 0, 16'h0);

        // Leading-zero suppression
        hex_in   = 16'h0050;
        lz_blank = 1'b1;
        run_frame(0, 0, 16'h0);
        hex_in = 16'h0000;
        run_frame(0, 0, 16'h0);

        // PWM duty, every position checked
        hex_in   = 16'h1234;
        lz_blank = 1'b0;
        bright   = 2'b01;
        run_frame(1, 0, 16'h0);
        bright = 2'b00;
        run_frame(1, 0, 16'h0);

        // Blink on digit 0, blanking on digit 2, across a full blink period
        bright   = 2'b11;
        blink_en = 4'b0001;
        blank_in = 4'b0100;
        for (int f = 0; f < 5; f++) run_frame(0, 0, 16'h0);

        // Reset mid-slot acts without a clock edge
        blink_en = 4'b0000;
        blank_in = 4'b0000;
        run_frame(0, 0, 16'h0);
        repeat (5) @(negedge clk);
        chk("pre_rst_an", {12'd0, an}, 16'h000E);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_an",   {12'd0, an},  16'h000F);
        chk("async_rst_sseg", {8'd0, sseg}, 16'h00FF);
        chk("async_rst_tick", {15'd0, frame_tick}, 16'd0);
        hex_in = 16'h5678;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            n++;
            if (frame_tick === 1'b1) break;
            if (n == 2) begin
                e = expect_out(0, 1, 1'b0);
                chk("post_rst_an",   {12'd0, an},  {12'd0, e[11:8]});
                chk("post_rst_sseg", {8'd0, sseg}, {8'd0, e[7:0]});
            end
        end
        chk("first_tick_cycle", n[15:0], 16'd64);
        run_frame(0, 0, 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
